// File: rtl/baud_tick_gen.sv
// Fractional baud-rate generator. It produces an oversample tick (os_tick), a per-bit
// tick (bit_tick) and a registered bit-rate square wave (out_clk) from in_clk.
// The divisor is div_int + div_frac/2^FRAC_W in_clk cycles per os_tick. A fractional
// accumulator inserts one extra cycle into a period whenever it carries.
// Optional feature: define BAUD_TICK_GEN_MIDTICK_EN to add mid_tick, a bit-centre strobe.

module baud_tick_gen #(
  parameter int unsigned F_IN       = 50_000_000,
  parameter int unsigned F_OUT      = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 4
) (
  input  logic              in_clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              resync,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              out_clk
`ifdef BAUD_TICK_GEN_MIDTICK_EN
  ,
  output logic              mid_tick
`endif
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  // Rounded fixed-point default divisor. With the default parameters it is 5208 (325 + 8/16).
  localparam longint unsigned DefNum = longint'(F_IN) * (longint'(1) << FRAC_W);
  localparam longint unsigned DefDen = longint'(F_OUT) * longint'(OVERSAMPLE);
  localparam longint unsigned DefDiv = (2 * DefNum + DefDen) / (2 * DefDen);
  localparam logic [DIV_W-1:0]  DefInt  = DIV_W'(DefDiv >> FRAC_W);
  localparam logic [FRAC_W-1:0] DefFrac = FRAC_W'(DefDiv);

  localparam logic [OS_W-1:0] OsLast = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OsHalf = OS_W'(OVERSAMPLE / 2);

  logic [DIV_W:0]    cnt_q, cnt_d;
  logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [DIV_W-1:0]  act_int_q, act_int_d, shd_int_q, shd_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d, shd_frac_q, shd_frac_d;
  logic              os_tick_q, os_tick_d;
  logic              bit_tick_q, bit_tick_d;
  logic              out_clk_q, out_clk_d;
  logic              mid_tick_q, mid_tick_d;

  logic [DIV_W-1:0]  eff_int;
  logic [DIV_W:0]    period_m1;
  logic              fire;

  // Next-state: divisor shadowing, period counter, fractional accumulator and tick outputs.
  always_comb begin
    shd_int_d  = div_load ? div_int  : shd_int_q;
    shd_frac_d = div_load ? div_frac : shd_frac_q;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    cnt_d      = cnt_q;
    os_cnt_d   = os_cnt_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    out_clk_d  = out_clk_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;

    eff_int   = (act_int_q < DIV_W'(2)) ? DIV_W'(2) : act_int_q;
    period_m1 = {1'b0, eff_int} + {{DIV_W{1'b0}}, carry_q} - {{DIV_W{1'b0}}, 1'b1};
    // Use >= so that a divisor shrunk while paused cannot strand the counter past its end.
    fire      = en && !resync && (cnt_q >= period_m1);

    if (resync) begin
      cnt_d      = '0;
      os_cnt_d   = '0;
      acc_d      = '0;
      carry_d    = 1'b0;
      out_clk_d  = 1'b0;
      act_int_d  = shd_int_d;
      act_frac_d = shd_frac_d;
    end else if (en) begin
      if (fire) begin
        // Period boundary: adopt the shadow divisor and set up the next period's carry.
        cnt_d              = '0;
        act_int_d          = shd_int_d;
        act_frac_d         = shd_frac_d;
        {carry_d, acc_d}   = {1'b0, acc_q} + {1'b0, shd_frac_d};
        os_cnt_d           = os_cnt_q + OS_W'(1);
        os_tick_d          = 1'b1;
        bit_tick_d         = (os_cnt_q == OsLast);
        mid_tick_d         = (os_cnt_q == OsHalf - OS_W'(1));
        out_clk_d          = (os_cnt_d >= OsHalf);
      end else begin
        cnt_d = cnt_q + {{DIV_W{1'b0}}, 1'b1};
      end
    end else begin
      // Paused: no period is running, so a new divisor can take effect at once.
      act_int_d  = shd_int_d;
      act_frac_d = shd_frac_d;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge in_clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q      <= '0;
      os_cnt_q   <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      act_int_q  <= DefInt;
      act_frac_q <= DefFrac;
      shd_int_q  <= DefInt;
      shd_frac_q <= DefFrac;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      out_clk_q  <= 1'b0;
      mid_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      os_cnt_q   <= os_cnt_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      shd_int_q  <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
      out_clk_q  <= out_clk_d;
      mid_tick_q <= mid_tick_d;
    end
  end

  assign os_tick  = os_tick_q;
  assign bit_tick = bit_tick_q;
  assign out_clk  = out_clk_q;

`ifdef BAUD_TICK_GEN_MIDTICK_EN
  assign mid_tick = mid_tick_q;
`else
  // mid_tick_q is left unconnected when the bit-centre strobe is not built.
`endif

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: default fractional rate, integer and fractional
// divisors, divisor reload, clamp, resync, enable stall and asynchronous reset.
// When BAUD_TICK_GEN_MIDTICK_EN is defined it also checks the mid_tick strobe.

module tb_baud_tick_gen;

  logic        in_clk = 1'b0;
  logic        nrst;
  logic        en;
  logic        resync;
  logic        div_load;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        os_tick;
  logic        bit_tick;
  logic        out_clk;
`ifdef BAUD_TICK_GEN_MIDTICK_EN
  logic        mid_tick;
`endif

  int checks = 0;
  int errors = 0;

  baud_tick_gen dut (
    .in_clk   (in_clk),
    .nrst     (nrst),
    .en       (en),
    .resync   (resync),
    .div_load (div_load),
    .div_int  (div_int),
    .div_frac (div_frac),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .out_clk  (out_clk)
`ifdef BAUD_TICK_GEN_MIDTICK_EN
    ,
    .mid_tick (mid_tick)
`endif
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Negedges from now until os_tick is seen high (bounded).
  task automatic next_os(output int dt);
    dt = 0;
    do begin
      @(negedge in_clk);
      dt++;
    end while (os_tick !== 1'b1 && dt < 2000);
  endtask

  // Negedges from now until bit_tick is seen high (bounded).
  task automatic next_bit(output int dt);
    dt = 0;
    do begin
      @(negedge in_clk);
      dt++;
    end while (bit_tick !== 1'b1 && dt < 20000);
  endtask

  task automatic load(input int i, input int f);
    div_int  = 16'(i);
    div_frac = 4'(f);
    div_load = 1'b1;
    @(negedge in_clk);
    div_load = 1'b0;
  endtask

  task automatic pulse_resync();
    resync = 1'b1;
    @(negedge in_clk);
    resync = 1'b0;
  endtask

  initial begin
    int dt;
    int dt2;
    int hi;
    logic quiet;

    nrst     = 1'b0;
    en       = 1'b1;
    resync   = 1'b0;
    div_load = 1'b0;
    div_int  = '0;
    div_frac = '0;

    // Reset state.
    repeat (3) @(negedge in_clk);
    check("rst_os_tick", 32'(os_tick), 0);
    check("rst_bit_tick", 32'(bit_tick), 0);
    check("rst_out_clk", 32'(out_clk), 0);
    nrst = 1'b1;

    // Default divisor 325 + 8/16: periods 325,325,326,325,326.
    next_os(dt); check("def_p1", dt, 325);
    next_os(dt); check("def_p2", dt, 325);
    next_os(dt); check("def_p3", dt, 326);
    next_os(dt); check("def_p4", dt, 325);
    next_os(dt); check("def_p5", dt, 326);

    // Integer divisor 4 from a resync.
    load(4, 0);
    pulse_resync();
    check("rsync_os_tick", 32'(os_tick), 0);
    check("rsync_out_clk", 32'(out_clk), 0);
    next_os(dt); check("div4_first", dt, 4);
    next_bit(dt); check("div4_bit_a", dt, 60);
    next_bit(dt); check("div4_bit_b", dt, 64);
    hi = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge in_clk);
      if (out_clk === 1'b1) hi++;
    end
    check("div4_out_hi", hi, 32);
    check("div4_bit_c", 32'(bit_tick), 1);
`ifdef BAUD_TICK_GEN_MIDTICK_EN
    dt = 0;
    do begin
      @(negedge in_clk);
      dt++;
    end while (mid_tick !== 1'b1 && dt < 200);
    check("mid_tick_pos", dt, 32);
    check("mid_with_os", 32'(os_tick), 1);
`endif

    // Reload mid-period: the running period finishes, then the new one applies.
    next_os(dt);
    @(negedge in_clk);
    load(8, 0);
    next_os(dt); check("load8_rem", dt, 2);
    next_os(dt); check("load8_per", dt, 8);
    next_os(dt);
    @(negedge in_clk);
    load(1, 0);
    next_os(dt); check("load1_rem", dt, 6);
    next_os(dt); check("clamp_p1", dt, 2);
    next_os(dt); check("clamp_p2", dt, 2);

    // Fractional 4 + 8/16: 4,4,5,4,5 then 144 cycles per two bits.
    load(4, 8);
    pulse_resync();
    next_os(dt); check("frac_p1", dt, 4);
    next_os(dt); check("frac_p2", dt, 4);
    next_os(dt); check("frac_p3", dt, 5);
    next_os(dt); check("frac_p4", dt, 4);
    next_os(dt); check("frac_p5", dt, 5);
    next_bit(dt);
    next_bit(dt);
    next_bit(dt2);
    check("frac_2bits", dt + dt2, 144);

    // Resync at os_cnt=9 restarts the bit without losing or doubling bit_ticks.
    load(4, 0);
    pulse_resync();
    next_bit(dt); check("rs_bit0", dt, 64);
    for (int i = 0; i < 9; i++) next_os(dt);
    check("rs_pre_out", 32'(out_clk), 1);
    pulse_resync();
    check("rs_out_clk", 32'(out_clk), 0);
    check("rs_no_tick", 32'(os_tick), 0);
    next_os(dt); check("rs_first_os", dt, 4);
    next_bit(dt); check("rs_bit1", dt, 60);

    // Enable low for 10 cycles stretches the period by exactly 10.
    next_os(dt);
    en = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge in_clk);
      if (os_tick !== 1'b0 || bit_tick !== 1'b0) quiet = 1'b0;
    end
    en = 1'b1;
    next_os(dt);
    check("en_quiet", 32'(quiet), 1);
    check("en_stretch", 10 + dt, 14);

    // Asynchronous reset mid-run clears outputs at once and restores the default divisor.
    next_bit(dt);
    for (int i = 0; i < 9; i++) next_os(dt);
    check("ar_pre_os", 32'(os_tick), 1);
    check("ar_pre_out", 32'(out_clk), 1);
    #1 nrst = 1'b0;
    #1;
    check("ar_os_tick", 32'(os_tick), 0);
    check("ar_out_clk", 32'(out_clk), 0);
    check("ar_bit_tick", 32'(bit_tick), 0);
    repeat (2) @(negedge in_clk);
    nrst = 1'b1;
    next_os(dt); check("ar_def_p1", dt, 325);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
